// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU decoder, condition check and
// the flag register, with the current FSM state exported on State for debug.
module arm_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q, cond_ex_r_d;

  logic       cond_ex;
  logic       next_pc, reg_w, mem_w, branch, ir_write, alu_op;
  logic       cmd_add, cmd_sub, rd_pc, pcs;
  logic [1:0] alu_dp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      flags_q     <= 4'b0000;
      cond_ex_r_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath selects and raw (ungated) strobes.
  always_comb begin
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        next_pc   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_add = (Funct[4:1] == 4'b0100);
  assign cmd_sub = (Funct[4:1] == 4'b0010);

  always_comb begin
    alu_dp = 2'b00;
    case (Funct[4:1])
      4'b0010: alu_dp = 2'b01;
      4'b0000: alu_dp = 2'b10;
      4'b1100: alu_dp = 2'b11;
      default: alu_dp = 2'b00;
    endcase
  end

  assign ALUControl = alu_op ? alu_dp : 2'b00;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};

  // flags_q is {N,Z,C,V}.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Condition is frozen at DECODE so a flag-setting EXECUTE cannot
  // change whether its own ALUWB writes back.
  assign cond_ex_r_d = (state_q == S_DECODE) ? cond_ex : cond_ex_r_q;

  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && Funct[0] && cond_ex_r_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cmd_add || cmd_sub) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  assign rd_pc = (Rd == 4'b1111);
  assign pcs   = (reg_w & rd_pc) | branch;

  assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_r_q));
  assign RegWrite = ~reset & reg_w & cond_ex_r_q & ~rd_pc;
  assign MemWrite = ~reset & mem_w & cond_ex_r_q;
  assign IRWrite  = ~reset & ir_write;
  assign State    = state_q;

endmodule
